// File: rtl/button_pulse_gen.sv
// Multi-channel button conditioner: two-flop synchronizer, debouncer and a
// per-channel repeat FSM. Each channel gives a one-cycle pulse when it is
// pressed and, if enabled, further auto-repeat pulses while it is held.
module button_pulse_gen #(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned DB_CYCLES     = 4,
  parameter int unsigned REPEAT_DELAY  = 10,
  parameter int unsigned REPEAT_PERIOD = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             repeat_en,
  output logic [N_BTN-1:0] pulse,
  output logic [N_BTN-1:0] level,
  output logic             any_pulse
);

  localparam int unsigned DbW    = (DB_CYCLES + 1 > 2) ? $clog2(DB_CYCLES + 1) : 1;
  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;

  localparam logic [DbW-1:0]  DbLast     = DbW'(DB_CYCLES - 1);
  localparam logic [RptW-1:0] DelayLast  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] PeriodLast = RptW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StHeld,
    StRepeat
  } rpt_state_e;

  logic [N_BTN-1:0] s1_q, s2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [N_BTN-1:0] rise, fall;
  logic [DbW-1:0]   db_cnt_q  [N_BTN];
  logic [DbW-1:0]   db_cnt_d  [N_BTN];
  logic [RptW-1:0]  rpt_cnt_q [N_BTN];
  logic [RptW-1:0]  rpt_cnt_d [N_BTN];
  rpt_state_e       state_q   [N_BTN];
  rpt_state_e       state_d   [N_BTN];

  // Synchronizer, debounce and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      level_q <= '0;
      pulse_q <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      s1_q    <= btn_raw;
      s2_q    <= s1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < N_BTN; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // Debounce: accept s2 only after it has differed from level for DB_CYCLES edges.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      level_d[i]  = level_q[i];
      db_cnt_d[i] = '0;
      if (s2_q[i] == level_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DbLast) begin
        level_d[i]  = s2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
      end
    end
  end

  // Edges of the debounced level as they are being registered this cycle.
  always_comb begin
    rise = level_d & ~level_q;
    fall = level_q & ~level_d;
  end

  // Repeat FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]   <= StIdle;
        rpt_cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        state_q[i]   <= state_d[i];
        rpt_cnt_q[i] <= rpt_cnt_d[i];
      end
    end
  end

  // Repeat FSM next state and counter; a falling level overrides everything.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i]   = state_q[i];
      rpt_cnt_d[i] = rpt_cnt_q[i];
      unique case (state_q[i])
        StIdle: begin
          rpt_cnt_d[i] = '0;
          if (rise[i]) begin
            state_d[i] = StHeld;
          end
        end
        StHeld: begin
          if (fall[i]) begin
            state_d[i]   = StIdle;
            rpt_cnt_d[i] = '0;
          end else if (!repeat_en) begin
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] == DelayLast) begin
            state_d[i]   = StRepeat;
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + RptW'(1);
          end
        end
        StRepeat: begin
          if (fall[i]) begin
            state_d[i]   = StIdle;
            rpt_cnt_d[i] = '0;
          end else if (!repeat_en) begin
            state_d[i]   = StHeld;
            rpt_cnt_d[i] = '0;
          end else if (rpt_cnt_q[i] == PeriodLast) begin
            rpt_cnt_d[i] = '0;
          end else begin
            rpt_cnt_d[i] = rpt_cnt_q[i] + RptW'(1);
          end
        end
        default: begin
          state_d[i]   = StIdle;
          rpt_cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Pulse decode: press pulse from IDLE, repeat pulses at the counter limit.
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      pulse_d[i] = 1'b0;
      unique case (state_q[i])
        StIdle:   pulse_d[i] = rise[i];
        StHeld:   pulse_d[i] = !fall[i] && repeat_en && (rpt_cnt_q[i] == DelayLast);
        StRepeat: pulse_d[i] = !fall[i] && repeat_en && (rpt_cnt_q[i] == PeriodLast);
        default:  pulse_d[i] = 1'b0;
      endcase
    end
  end

  assign pulse     = pulse_q;
  assign level     = level_q;
  assign any_pulse = |pulse_q;

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen. Expected pulses are queued with the edge
// number they must appear on; a negedge monitor compares pulse/any_pulse every cycle.
module tb_button_pulse_gen;

  logic       clk;
  logic       rst;
  logic [3:0] btn_raw;
  logic       repeat_en;
  logic [3:0] pulse;
  logic [3:0] level;
  logic       any_pulse;

  int unsigned vectors;
  int unsigned miscompares;
  int unsigned cyc;
  bit          mon_en;

  typedef struct {
    int unsigned edge_n;
    logic [3:0]  mask;
  } exp_t;

  exp_t sb[$];

  button_pulse_gen #(
    .N_BTN        (4),
    .DB_CYCLES    (4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .repeat_en(repeat_en),
    .pulse    (pulse),
    .level    (level),
    .any_pulse(any_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s at edge %0d: observed %b expected %b", tag, cyc, obs, exp_v);
    end
  endtask

  // Insert in edge order, merging channels expected on the same edge.
  function automatic void expect_pulse(input int unsigned e, input logic [3:0] m);
    exp_t it;
    it.edge_n = e;
    it.mask   = m;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].edge_n == e) begin
        sb[i].mask = sb[i].mask | m;
        return;
      end
      if (sb[i].edge_n > e) begin
        sb.insert(i, it);
        return;
      end
    end
    sb.push_back(it);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pulse must be zero unless an entry is due this edge.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [3:0] exp_m;
      exp_m = 4'b0000;
      if (sb.size() > 0 && sb[0].edge_n == cyc) begin
        exp_m = sb[0].mask;
        void'(sb.pop_front());
      end
      chk("pulse", pulse, exp_m);
      chk("any_pulse", {3'b000, any_pulse}, {3'b000, |exp_m});
    end
  end

  initial begin
    int unsigned e;
    int unsigned t;
    int unsigned u;
    int unsigned r;
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    rst         = 1'b1;
    btn_raw     = 4'b0000;
    repeat_en   = 1'b0;

    // Reset state
    step(3);
    chk("reset_level", level, 4'b0000);
    chk("reset_pulse", pulse, 4'b0000);
    chk("reset_any", {3'b000, any_pulse}, 4'b0000);
    rst    = 1'b0;
    mon_en = 1'b1;
    step(2);

    // Clean press on channel 0: first sampled one edge after driving, level six edges later
    e = cyc;
    btn_raw[0] = 1'b1;
    expect_pulse(e + 6, 4'b0001);
    step(5);
    chk("press_level_early", level, 4'b0000);
    step(1);
    chk("press_level_rise", level, 4'b0001);
    step(4);
    btn_raw[0] = 1'b0;
    step(8);
    chk("release_level", level, 4'b0000);

    // Bounce on channel 1, then hold: single pulse from the final rising edge
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    btn_raw[1] = 1'b1; step(1);
    btn_raw[1] = 1'b0; step(1);
    e = cyc;
    btn_raw[1] = 1'b1;
    expect_pulse(e + 6, 4'b0010);
    step(10);
    chk("bounce_level", level, 4'b0010);
    btn_raw[1] = 1'b0;
    step(8);

    // Auto-repeat on channel 2; release lands on a repeat-counter limit edge
    repeat_en = 1'b1;
    e = cyc;
    t = e + 6;
    btn_raw[2] = 1'b1;
    expect_pulse(t, 4'b0100);
    expect_pulse(t + 10, 4'b0100);
    expect_pulse(t + 15, 4'b0100);
    expect_pulse(t + 20, 4'b0100);
    expect_pulse(t + 25, 4'b0100);
    step(30);
    chk("repeat_level_held", level, 4'b0100);
    btn_raw[2] = 1'b0;
    step(6);
    chk("repeat_level_fall", level, 4'b0000);
    step(8);

    // Repeat gating: only the press pulse until repeat_en returns
    repeat_en = 1'b0;
    e = cyc;
    t = e + 6;
    btn_raw[2] = 1'b1;
    expect_pulse(t, 4'b0100);
    step(18);
    u = cyc;
    repeat_en = 1'b1;
    expect_pulse(u + 10, 4'b0100);
    expect_pulse(u + 15, 4'b0100);
    step(12);
    btn_raw[2] = 1'b0;
    step(8);
    repeat_en = 1'b0;
    step(2);

    // Reset during REPEAT on channel 3 with the button still held
    repeat_en = 1'b1;
    e = cyc;
    t = e + 6;
    btn_raw[3] = 1'b1;
    expect_pulse(t, 4'b1000);
    expect_pulse(t + 10, 4'b1000);
    step(18);
    rst = 1'b1;
    step(1);
    r = cyc;
    chk("midrst_level", level, 4'b0000);
    chk("midrst_pulse", pulse, 4'b0000);
    chk("midrst_any", {3'b000, any_pulse}, 4'b0000);
    rst = 1'b0;
    expect_pulse(r + 6, 4'b1000);
    step(5);
    chk("postrst_level_early", level, 4'b0000);
    step(1);
    chk("postrst_level", level, 4'b1000);
    step(1);
    repeat_en  = 1'b0;
    btn_raw[3] = 1'b0;
    step(8);

    // Simultaneous presses on 0 and 3, 3-cycle glitch on 1
    e = cyc;
    btn_raw = 4'b1011;
    expect_pulse(e + 6, 4'b1001);
    step(3);
    btn_raw[1] = 1'b0;
    step(3);
    chk("multi_level", level, 4'b1001);
    step(2);
    btn_raw = 4'b0000;
    step(8);
    chk("multi_release", level, 4'b0000);
    step(2);

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
    end
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
